// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields back into instruction words and streams them
// out with addresses through a small FIFO, flagging illegal immediates.
module instr_encoder #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_illegal,
    output logic [15:0] illegal_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   ill_cnt_q, ill_cnt_d;
    logic [32:0]   mem_q [DEPTH];
    logic [32:0]   mem_d [DEPTH];

    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        push, pop;
    logic [32:0] head;
    logic        imm_i_ok, imm_b_ok, imm_j_ok, imm_u_ok, shamt_ok;

    assign imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign imm_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign imm_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign imm_u_ok = ~(|in_imm[11:0]);
    assign shamt_ok = ~(|in_imm[31:5]);

    always_comb begin
        enc_instr   = 32'h0000_0013;
        enc_illegal = 1'b0;
        case (in_opcode)
            7'b0110011: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            7'b0010011: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    enc_instr   = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_illegal = ~shamt_ok;
                end else begin
                    enc_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_illegal = ~imm_i_ok;
                end
            end
            7'b0000011, 7'b1100111, 7'b0001111: begin
                enc_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_illegal = ~imm_i_ok;
            end
            7'b0100011: begin
                enc_instr   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_illegal = ~imm_i_ok;
            end
            7'b1100011: begin
                enc_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
                enc_illegal = ~imm_b_ok;
            end
            7'b1101111: begin
                enc_instr   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_illegal = ~imm_j_ok;
            end
            7'b0110111, 7'b0010111: begin
                enc_instr   = {in_imm[31:12], in_rd, in_opcode};
                enc_illegal = ~imm_u_ok;
            end
            default: begin
                enc_instr   = 32'h0000_0013;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // in_ready depends only on stored occupancy, never on out_ready
    assign in_ready      = (count_q != CW'(DEPTH));
    assign out_valid     = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign out_instr     = out_valid ? head[31:0] : 32'h0;
    assign out_illegal   = out_valid & head[32];
    assign out_addr      = addr_q;
    assign illegal_count = ill_cnt_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        ill_cnt_d = ill_cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = {enc_illegal, enc_instr};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            addr_d   = addr_q + 32'd4;
            if (head[32] && ill_cnt_q != 16'hFFFF) begin
                ill_cnt_d = ill_cnt_q + 16'd1;
            end
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= RESET_ADDR;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a queue-based
// reference model that encodes from field positions with plain arithmetic.
module tb_instr_encoder;
    localparam int          DEPTH      = 2;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_illegal;
    logic [15:0] illegal_count;

    instr_encoder #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    bit [31:0]   q_w[$];
    bit          q_ill[$];
    bit [31:0]   m_addr;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] fld(input bit [31:0] x, input int lo, input int n);
        return (x >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic void ref_encode(
        input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
        input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
        input bit [31:0] imm, output bit [31:0] w, output bit ill);
        int si;
        bit [31:0] regs;
        si   = imm;
        regs = (32'(rs1) << 15) + (32'(f3) << 12) + 32'(op);
        ill  = 1'b0;
        case (op)
            7'h33: w = (32'(f7) << 25) + (32'(rs2) << 20) + regs + (32'(rd) << 7);
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w   = (32'(f7) << 25) + (fld(imm, 0, 5) << 20) + regs + (32'(rd) << 7);
                    ill = imm > 32'd31;
                end else begin
                    w   = (fld(imm, 0, 12) << 20) + regs + (32'(rd) << 7);
                    ill = si < -2048 || si > 2047;
                end
            end
            7'h03, 7'h67, 7'h0F: begin
                w   = (fld(imm, 0, 12) << 20) + regs + (32'(rd) << 7);
                ill = si < -2048 || si > 2047;
            end
            7'h23: begin
                w   = (fld(imm, 5, 7) << 25) + (32'(rs2) << 20) + regs + (fld(imm, 0, 5) << 7);
                ill = si < -2048 || si > 2047;
            end
            7'h63: begin
                w   = (fld(imm, 12, 1) << 31) + (fld(imm, 5, 6) << 25) + (32'(rs2) << 20) + regs
                    + (fld(imm, 1, 4) << 8) + (fld(imm, 11, 1) << 7);
                ill = si < -4096 || si > 4095 || (si % 2) != 0;
            end
            7'h6F: begin
                w   = (fld(imm, 20, 1) << 31) + (fld(imm, 1, 10) << 21) + (fld(imm, 11, 1) << 20)
                    + (fld(imm, 12, 8) << 12) + (32'(rd) << 7) + 32'(op);
                ill = si < -1048576 || si > 1048575 || (si % 2) != 0;
            end
            7'h37, 7'h17: begin
                w   = (imm & 32'hFFFF_F000) + (32'(rd) << 7) + 32'(op);
                ill = (imm % 4096) != 0;
            end
            default: begin
                w   = 32'h0000_0013;
                ill = 1'b1;
            end
        endcase
    endfunction

    // Check outputs against the model, clock once, then advance the model
    task automatic cycle();
        bit push, pop, ill;
        bit [31:0] w;
        check("in_ready", 32'(in_ready), 32'(q_w.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(q_w.size() != 0));
        check("ill_cnt", 32'(illegal_count), m_cnt);
        if (q_w.size() != 0) begin
            check("instr", out_instr, q_w[0]);
            check("addr", out_addr, m_addr);
            check("illegal", 32'(out_illegal), 32'(q_ill[0]));
        end
        push = in_valid && (q_w.size() < DEPTH);
        pop  = (q_w.size() != 0) && out_ready;
        ref_encode(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, w, ill);
        @(posedge clk);
        #1;
        if (pop) begin
            if (q_ill[0] && m_cnt < 32'hFFFF) m_cnt++;
            void'(q_w.pop_front());
            void'(q_ill.pop_front());
            m_addr += 32'd4;
        end
        if (push) begin
            q_w.push_back(w);
            q_ill.push_back(ill);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_w.delete();
        q_ill.delete();
        m_addr = RESET_ADDR;
        m_cnt  = 0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        check("rst_addr", out_addr, RESET_ADDR);
        check("rst_cnt", 32'(illegal_count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic set_in(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                          input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit [31:0] imm);
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic expect_head(input string tag, input bit [31:0] instr,
                               input bit [31:0] addr, input bit ill);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, instr);
        check({tag, "_addr"}, out_addr, addr);
        check({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    bit [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F,
                           7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

    function automatic bit [31:0] rand_imm();
        bit [31:0] edge_v [12] = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF,
                                   32'd31, 32'd32, 32'd4094, 32'd4095, 32'hFFFF_F000,
                                   32'h000F_FFFE, 32'h0010_0000, 32'hFFF0_0000};
        case ($urandom_range(0, 4))
            0: return $urandom_range(0, 63);
            1: return 32'($signed(-$urandom_range(0, 5000)));
            2: return edge_v[$urandom_range(0, 11)];
            3: return $urandom & 32'hFFFF_F000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        do_reset();

        // add x3,x1,x2
        out_ready = 1'b1;
        set_in(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        cycle();
        in_valid = 1'b0;
        expect_head("add", 32'h002081B3, 32'h0, 1'b0);
        cycle();

        // back-to-back addi / sw / srai
        do_reset();
        set_in(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle();
        expect_head("addi", 32'h00500093, 32'h0, 1'b0);
        set_in(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        cycle();
        expect_head("sw", 32'h0020A423, 32'h4, 1'b0);
        set_in(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3);
        cycle();
        in_valid = 1'b0;
        expect_head("srai", 32'h4030D093, 32'h8, 1'b0);
        cycle();

        // beq / jal / lui
        set_in(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        cycle();
        expect_head("beq", 32'hFE208CE3, 32'hC, 1'b0);
        set_in(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
        cycle();
        expect_head("jal", 32'h001000EF, 32'h10, 1'b0);
        set_in(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        cycle();
        in_valid = 1'b0;
        expect_head("lui", 32'h123452B7, 32'h14, 1'b0);
        cycle();

        // two illegal words
        do_reset();
        set_in(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        cycle();
        check("beq_odd_ill", 32'(out_illegal), 32'd1);
        set_in(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        cycle();
        in_valid = 1'b0;
        expect_head("badop", 32'h0000_0013, 32'h4, 1'b1);
        cycle();
        check("ill_cnt_2", 32'(illegal_count), 32'd2);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        set_in(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle();
        set_in(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        cycle();
        set_in(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 32'(in_ready), 32'd0);
            expect_head("bp_hold", 32'h00500093, 32'h0, 1'b0);
            cycle();
        end
        out_ready = 1'b1;
        expect_head("bp0", 32'h00500093, 32'h0, 1'b0);
        cycle();
        expect_head("bp1", 32'h0020A423, 32'h4, 1'b0);
        cycle();
        in_valid = 1'b0;
        expect_head("bp2", 32'h4030D093, 32'h8, 1'b0);
        cycle();

        // reset with words buffered
        out_ready = 1'b0;
        set_in(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle();
        cycle();
        do_reset();
        out_ready = 1'b1;
        set_in(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        cycle();
        in_valid = 1'b0;
        expect_head("post_rst", 32'h002081B3, 32'h0, 1'b0);
        cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_imm    = rand_imm();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction-decode stage: packs decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7, sign-extended immediate) back into a 32-bit RV32I instruction word.
- Streams the words out with addresses, for writing into instruction memory.
- Used by the program loader and by self-checking benches.
- Valid/ready on both sides, a small output FIFO, a running address counter, and per-word immediate-legality checking.

Parameters:
- RESET_ADDR, 32'h0000_0000, address tagged on the first emitted word after reset.
- DEPTH, 2, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  7  opcode
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type, and I-type shifts)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  sign-extended immediate (same convention decode produces; U-type already shifted, i.e. low 12 bits zero)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  32  address of out_instr
- out_illegal  out  1  word's fields failed legality check
- illegal_count  out  16  saturating count of illegal words emitted

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; out_valid=0, out_instr=0, out_illegal=0.
  - out_addr=RESET_ADDR; illegal_count=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-stream discards all buffered words.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !fifo_full. It is registered state only, with no combinational path from out_ready.
- Full FIFO with a same-cycle pop: no push occurs. in_ready is already 0, so there is no pass-through.
- Latency: a bundle accepted in cycle N is encoded combinationally, written to the FIFO at the end of N, and visible on out_* in cycle N+1 if the FIFO was empty.
- Output handshake:
  - Word pops when out_valid && out_ready.
  - out_instr and out_illegal are stable while out_valid && !out_ready.
  - Push and pop in the same cycle with the FIFO neither full nor empty: occupancy unchanged.
- Address counter:
  - out_addr is the address of the head word.
  - Increments by 4 on each pop, wrapping modulo 2^32.
  - Illegal words also consume an address.
- Encoding by opcode:
  - RType 0110011: {funct7, rs2, rs1, funct3, rd, op}.
  - IType_logic 0010011:
    - funct3=001 or 101 (shifts): {funct7, imm[4:0], rs1, funct3, rd, op}.
    - Otherwise: {imm[11:0], rs1, funct3, rd, op}.
  - IType_load 0000011, IType_jalr 1100111, FENCE 0001111: {imm[11:0], rs1, funct3, rd, op}.
  - SType 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - BType 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - JType 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - UType_lui 0110111, UType_auipc 0010111: {imm[31:12], rd, op}.
  - Any other opcode: emit 32'h0000_0013 (NOP) with illegal=1.
- Legality (illegal=1 if any condition fails; the word is still encoded from truncated fields):
  - I/S/FENCE: in_imm[31:11] all equal.
  - Shifts: in_imm[31:5]==0.
  - B: in_imm[31:12] all equal and in_imm[0]==0.
  - J: in_imm[31:20] all equal and in_imm[0]==0.
  - U: in_imm[11:0]==0.
- illegal_count increments on pop of a word with out_illegal=1 and saturates at 16'hFFFF.

Test Plan:
- Reset, then push add x3,x1,x2 (RType, f3=0, f7=0), with out_ready=1 -> out_instr=0x002081B3, out_addr=0x0, out_valid in the next cycle.
- Push back-to-back:
  - addi x1,x0,5 -> 0x00500093, addr 0x0.
  - sw x2,8(x1) -> 0x0020A423, addr 0x4.
  - srai x1,x1,3 (f7=0100000) -> 0x4030D093, addr 0x8.
- Push beq x1,x2,imm=-8 -> 0xFE208CE3. Push jal x1,imm=0x800 -> 0x001000EF. Push lui x5,imm=0x12345000 -> 0x123452B7. All three with out_illegal=0.
- Push beq with imm=3 and opcode 7'b1111111 -> both out_illegal=1 (second word 0x00000013); illegal_count=2 after both pop.
- Backpressure, out_ready=0:
  - After 2 pushes, in_ready=0, the third bundle is held, and the head word is stable.
  - Raise out_ready: the order is preserved, with addresses 0x0, 0x4, 0x8.
- Reset while 2 words are buffered -> out_valid=0 the next cycle, out_addr=RESET_ADDR, and the next push emits at 0x0.
